hack_memory_map: RTL and testbench

- Data-memory subsystem directly downstream of the Hack CPU. Consumes addressM/outM/writeM and returns inM.
- Decodes the Hack address space into three regions: RAM, screen buffer and keyboard.
- The keyboard side is a buffered key-code FIFO fed by a valid/ready source.
- The screen buffer has a second, registered read port for the display scanner.

---
 rtl/hack_memory_map.sv | 118 +++++++++++
 tb/tb_hack_memory_map.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_memory_map.sv
// Hack data-memory map: 16K RAM, 8K screen with a registered scanner port, and a key-code FIFO at 0x6000.
// Optional HACK_MEM_KBD_STATUS_EN adds a keyboard status/overflow register at 0x6001.
module hack_memory_map #(
   parameter int KBD_DEPTH = 8,
   parameter int KBD_AW    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [14:0] addressM,
   input  logic [15:0] outM,
   input  logic        writeM,
   output logic [15:0] inM,
   input  logic [15:0] key_data,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [12:0] scr_addr,
   output logic [15:0] scr_data
);

   localparam logic [14:0]     KBD_ADDR  = 15'h6000;
   localparam logic [KBD_AW:0] FULL_CNT  = (KBD_AW + 1)'(KBD_DEPTH);

   logic [15:0] ram      [0:16383];
   logic [15:0] screen   [0:8191];
   logic [15:0] kbd_fifo [0:KBD_DEPTH-1];

   logic [KBD_AW-1:0] head;
   logic [KBD_AW-1:0] tail;
   logic [KBD_AW:0]   count;

   logic sel_ram;
   logic sel_scr;
   logic sel_kbd;
   logic fifo_empty;
   logic push;
   logic pop;

   assign sel_ram    = ~addressM[14];
   assign sel_scr    = (addressM[14:13] == 2'b10);
   assign sel_kbd    = (addressM == KBD_ADDR);
   assign fifo_empty = (count == '0);
   assign key_ready  = (count != FULL_CNT);

   // A zero key code completes the handshake but is never stored.
   assign push = key_valid & key_ready & (key_data != 16'h0000);
   assign pop  = writeM & sel_kbd & ~fifo_empty;

   always_ff @(posedge clock) begin
      if (writeM && sel_ram)
         ram[addressM[13:0]] <= outM;
      if (writeM && sel_scr)
         screen[addressM[12:0]] <= outM;
      if (push)
         kbd_fifo[tail] <= key_data;
   end

   // Scanner port reads the pre-write word when the CPU hits the same address.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         scr_data <= 16'h0000;
      else
         scr_data <= screen[scr_addr];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop)
            head <= head + 1'b1;
         if (push)
            tail <= tail + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef HACK_MEM_KBD_STATUS_EN
   localparam logic [14:0] STAT_ADDR = 15'h6001;

   logic       sel_stat;
   logic       overflow;
   logic [8:0] count_ext;

   assign sel_stat  = (addressM == STAT_ADDR);
   assign count_ext = 9'(count);

   // Set has priority over a same-cycle CPU clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         overflow <= 1'b0;
      else if (key_valid && !key_ready)
         overflow <= 1'b1;
      else if (writeM && sel_stat)
         overflow <= 1'b0;
   end
`endif

   always_comb begin
      inM = 16'h0000;
      if (sel_ram)
         inM = ram[addressM[13:0]];
      else if (sel_scr)
         inM = screen[addressM[12:0]];
      else if (sel_kbd)
         inM = fifo_empty ? 16'h0000 : kbd_fifo[head];
`ifdef HACK_MEM_KBD_STATUS_EN
      else if (sel_stat)
         inM = {overflow, 6'b000000, count_ext};
`endif
   end

endmodule

// File: tb/tb_hack_memory_map.sv
// Bench for hack_memory_map: directed scenarios plus a randomized run against a queue/array model.
module tb_hack_memory_map;

   localparam int DEPTH = 8;
`ifdef HACK_MEM_KBD_STATUS_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [14:0] addressM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;
   logic [15:0] key_data;
   logic        key_valid;
   logic        key_ready;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;

   int total = 0;
   int bad   = 0;

   // Reference model
   logic [15:0] ram_m [16384];
   bit          ram_k [16384];
   logic [15:0] scr_m [8192];
   bit          scr_k [8192];
   logic [15:0] q[$];
   bit          ovf;
   logic [15:0] exp_scr;
   bit          exp_scr_k;

   hack_memory_map #(.KBD_DEPTH(8), .KBD_AW(3)) dut (
      .clock(clock), .reset(reset), .addressM(addressM), .outM(outM),
      .writeM(writeM), .inM(inM), .key_data(key_data), .key_valid(key_valid),
      .key_ready(key_ready), .scr_addr(scr_addr), .scr_data(scr_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      q.delete();
      ovf       = 1'b0;
      exp_scr   = 16'h0000;
      exp_scr_k = 1'b1;
   endtask

   function automatic logic [15:0] m_read(input logic [14:0] a, output bit k);
      k = 1'b1;
      if (a < 15'h4000) begin
         k = ram_k[a[13:0]];
         return ram_m[a[13:0]];
      end else if (a < 15'h6000) begin
         k = scr_k[a[12:0]];
         return scr_m[a[12:0]];
      end else if (a == 15'h6000) begin
         return (q.size() > 0) ? q[0] : 16'h0000;
      end else if (a == 15'h6001 && STAT_EN) begin
         return {ovf, 6'b000000, 9'(q.size())};
      end
      return 16'h0000;
   endfunction

   // One clock edge: model effects are computed from the inputs present before the edge.
   task automatic cycle();
      bit rst_s, rdy, pp, ps, clr, wr, oset, snk;
      logic [14:0] a;
      logic [15:0] d, kd, sn;
      rst_s = reset; a = addressM; d = outM; wr = writeM; kd = key_data;
      rdy  = (q.size() != DEPTH);
      pp   = wr && (a == 15'h6000) && (q.size() > 0);
      ps   = key_valid && rdy && (kd != 16'h0000);
      clr  = wr && (a == 15'h6001);
      oset = key_valid && !rdy;
      sn   = scr_m[scr_addr];
      snk  = scr_k[scr_addr];
      @(posedge clock);
      if (!rst_s) begin
         model_reset();
      end else begin
         exp_scr = sn; exp_scr_k = snk;
         if (wr && !a[14]) begin ram_m[a[13:0]] = d; ram_k[a[13:0]] = 1'b1; end
         if (wr && a[14:13] == 2'b10) begin scr_m[a[12:0]] = d; scr_k[a[12:0]] = 1'b1; end
         if (pp) void'(q.pop_front());
         if (ps) q.push_back(kd);
         if (oset) ovf = 1'b1;
         else if (clr) ovf = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      cycle(); cycle();
      addressM = 15'h6000;
      #1;
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
      total++; if (scr_data !== 16'h0000) begin bad++; $display("FAIL reset_scr_data got=%h exp=0000", scr_data); end
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL reset_kbd got=%h exp=0000", inM); end
      addressM = 15'h6001;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=0000", inM); end
      reset = 1'b1;
      cycle();
      $display("txn reset released");
   endtask

   task automatic test_ram();
      addressM = 15'h4000; outM = 16'hBEEF; writeM = 1'b1; cycle();
      addressM = 15'h0005; outM = 16'h1111; cycle();
      outM = 16'h1234;
      #1;
      total++; if (inM !== 16'h1111) begin bad++; $display("FAIL ram_rdw_old got=%h exp=1111", inM); end
      cycle();
      writeM = 1'b0;
      #1;
      total++; if (inM !== 16'h1234) begin bad++; $display("FAIL ram_read got=%h exp=1234", inM); end
      addressM = 15'h4000;
      #1;
      total++; if (inM !== 16'hBEEF) begin bad++; $display("FAIL ram_screen_unaffected got=%h exp=beef", inM); end
      $display("txn ram write 0005=1234");
   endtask

   task automatic test_screen();
      addressM = 15'h4010; outM = 16'hFFFF; writeM = 1'b1; cycle();
      writeM = 1'b0; scr_addr = 13'h0010; cycle();
      total++; if (scr_data !== 16'hFFFF) begin bad++; $display("FAIL scr_port got=%h exp=ffff", scr_data); end
      total++; if (inM !== 16'hFFFF) begin bad++; $display("FAIL scr_cpu_read got=%h exp=ffff", inM); end
      outM = 16'hAAAA; writeM = 1'b1; cycle();
      writeM = 1'b0;
      #1;
      total++; if (scr_data !== 16'hFFFF) begin bad++; $display("FAIL scr_collision_old got=%h exp=ffff", scr_data); end
      cycle();
      total++; if (scr_data !== 16'hAAAA) begin bad++; $display("FAIL scr_after_write got=%h exp=aaaa", scr_data); end
      $display("txn screen write 4010");
   endtask

   task automatic test_kbd_basic();
      key_valid = 1'b1; key_data = 16'h0041; cycle();
      key_data = 16'h0042; cycle();
      key_valid = 1'b0; addressM = 15'h6000;
      #1;
      total++; if (inM !== 16'h0041) begin bad++; $display("FAIL kbd_head1 got=%h exp=0041", inM); end
      writeM = 1'b1; cycle();
      total++; if (inM !== 16'h0042) begin bad++; $display("FAIL kbd_head2 got=%h exp=0042", inM); end
      cycle();
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL kbd_empty got=%h exp=0000", inM); end
      cycle();
      writeM = 1'b0;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL kbd_pop_empty got=%h exp=0000", inM); end
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL kbd_ready_empty got=%b exp=1", key_ready); end
      addressM = 15'h6001;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL kbd_count_zero got=%h exp=0000", inM); end
      $display("txn kbd push 41,42 pop x3");
   endtask

   task automatic test_kbd_full();
      logic [15:0] exp_st;
      for (int i = 0; i < 9; i++) begin
         key_valid = 1'b1; key_data = 16'h0101 + 16'(i);
         #1;
         total++;
         if (key_ready !== (i < 8)) begin bad++; $display("FAIL full_ready_%0d got=%b exp=%b", i, key_ready, (i < 8)); end
         cycle();
      end
      key_valid = 1'b0; addressM = 15'h6001;
      #1;
      exp_st = STAT_EN ? 16'h8008 : 16'h0000;
      total++; if (inM !== exp_st) begin bad++; $display("FAIL status_ovf got=%h exp=%h", inM, exp_st); end
      writeM = 1'b1; cycle();
      writeM = 1'b0;
      #1;
      exp_st = STAT_EN ? 16'h0008 : 16'h0000;
      total++; if (inM !== exp_st) begin bad++; $display("FAIL status_clear got=%h exp=%h", inM, exp_st); end
      key_valid = 1'b1; writeM = 1'b1; cycle();
      key_valid = 1'b0; writeM = 1'b0;
      #1;
      exp_st = STAT_EN ? 16'h8008 : 16'h0000;
      total++; if (inM !== exp_st) begin bad++; $display("FAIL status_set_wins got=%h exp=%h", inM, exp_st); end
      // Pop while full with the ninth key still offered.
      key_valid = 1'b1; key_data = 16'h0109; addressM = 15'h6000; writeM = 1'b1;
      #1;
      total++; if (inM !== 16'h0101) begin bad++; $display("FAIL full_head got=%h exp=0101", inM); end
      cycle();
      writeM = 1'b0;
      #1;
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL full_ready_rise got=%b exp=1", key_ready); end
      cycle();
      key_valid = 1'b0;
      #1;
      total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL full_again got=%b exp=0", key_ready); end
      for (int i = 0; i < 8; i++) begin
         writeM = 1'b1;
         #1;
         total++;
         if (inM !== 16'h0102 + 16'(i)) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, inM, 16'h0102 + 16'(i)); end
         cycle();
      end
      addressM = 15'h6001; cycle();
      writeM = 1'b0; addressM = 15'h6000;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL drain_empty got=%h exp=0000", inM); end
      $display("txn kbd fill 9 / overflow / drain");
   endtask

   task automatic test_zero_and_simul();
      key_valid = 1'b1; key_data = 16'h0000; addressM = 15'h6000; cycle();
      key_valid = 1'b0;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL zero_key got=%h exp=0000", inM); end
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", key_ready); end
      key_valid = 1'b1; key_data = 16'h0051; writeM = 1'b1; cycle();
      key_valid = 1'b0; writeM = 1'b0;
      #1;
      total++; if (inM !== 16'h0051) begin bad++; $display("FAIL simul_empty got=%h exp=0051", inM); end
      writeM = 1'b1; cycle();
      writeM = 1'b0;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL simul_pop got=%h exp=0000", inM); end
      $display("txn kbd zero key / push+pop on empty");
   endtask

   task automatic test_reset_mid();
      addressM = 15'h0100; outM = 16'hCAFE; writeM = 1'b1; cycle();
      writeM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         key_valid = 1'b1; key_data = 16'h0031 + 16'(i); cycle();
      end
      key_data = 16'h0077; addressM = 15'h6000; writeM = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", key_ready); end
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL midrst_kbd got=%h exp=0000", inM); end
      cycle();
      reset = 1'b1; key_valid = 1'b0; writeM = 1'b0; addressM = 15'h0100;
      #1;
      total++; if (inM !== 16'hCAFE) begin bad++; $display("FAIL midrst_ram got=%h exp=cafe", inM); end
      addressM = 15'h7000;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL unmapped got=%h exp=0000", inM); end
      cycle();
      addressM = 15'h6000;
      #1;
      total++; if (inM !== 16'h0000) begin bad++; $display("FAIL midrst_discard got=%h exp=0000", inM); end
      $display("txn reset mid-operation");
   endtask

   task automatic test_random();
      logic [15:0] e;
      bit k;
      for (int c = 0; c < 400; c++) begin
         case ($urandom_range(0, 5))
            0, 1:    addressM = 15'h0200 + 15'($urandom_range(0, 15));
            2:       addressM = 15'h4000 + 15'($urandom_range(0, 15));
            3:       addressM = 15'h6000;
            4:       addressM = 15'h6001;
            default: addressM = 15'($urandom_range(15'h6002, 15'h7FFF));
         endcase
         writeM    = 1'($urandom_range(0, 1));
         outM      = 16'($urandom);
         key_valid = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         key_data  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         scr_addr  = 13'($urandom_range(0, 16));
         #1;
         e = m_read(addressM, k);
         if (k) begin
            total++;
            if (inM !== e) begin bad++; $display("FAIL rand_inM c=%0d addr=%h got=%h exp=%h", c, addressM, inM, e); end
         end
         total++;
         if (key_ready !== (q.size() != DEPTH)) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, key_ready, (q.size() != DEPTH)); end
         if (exp_scr_k) begin
            total++;
            if (scr_data !== exp_scr) begin bad++; $display("FAIL rand_scr c=%0d got=%h exp=%h", c, scr_data, exp_scr); end
         end
         if (c % 50 == 0) $display("txn random c=%0d addr=%h wr=%b depth=%0d", c, addressM, writeM, q.size());
         cycle();
      end
      writeM = 1'b0; key_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; addressM = '0; outM = '0; writeM = 1'b0;
      key_data = '0; key_valid = 1'b0; scr_addr = '0;
      ovf = 1'b0; exp_scr = '0; exp_scr_k = 1'b0;
      for (int i = 0; i < 16384; i++) ram_k[i] = 1'b0;
      for (int i = 0; i < 8192; i++) scr_k[i] = 1'b0;
      #3;
      test_reset();
      test_ram();
      test_screen();
      test_kbd_basic();
      test_kbd_full();
      test_zero_and_simul();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
